// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word-load handshake and serial/status outputs of uart_word_tx.
interface uart_word_tx_if;
  logic [31:0] word_in;
  logic        start;
  logic        tx;
  logic        busy;
  logic        done;
  modport master (output word_in, start, input tx, busy, done);
  modport slave  (input word_in, start, output tx, busy, done);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a 32-bit word as NUM_BYTES back-to-back 8N1 UART frames, low byte first.
module uart_word_tx #(
  parameter int BAUD_DIV  = 10417,
  parameter int NUM_BYTES = 4
) (
  input logic           clk,
  input logic           reset,
  uart_word_tx_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);
  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] sh, sh_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n;
  logic tx_q, tx_n, busy_q, busy_n, done_q, done_n;
  logic tick;
  assign tick = cnt == LAST_CNT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  // tx is computed one cycle ahead so the line changes only on a bit boundary edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = START_BIT;
        cnt_n   = '0;
        sh_n    = bus.word_in;
        bit_n   = '0;
        byte_n  = '0;
        tx_n    = 1'b0;
        busy_n  = 1'b1;
      end
    end else begin
      cnt_n = tick ? '0 : cnt + 1'b1;
      if (tick)
        case (state)
          START_BIT: begin
            state_n = DATA_BITS;
            tx_n    = sh[0];
            sh_n    = sh >> 1;
            bit_n   = '0;
          end
          DATA_BITS:
            if (bit_idx == 3'd7) begin
              state_n = STOP_BIT;
              tx_n    = 1'b1;
            end else begin
              tx_n  = sh[0];
              sh_n  = sh >> 1;
              bit_n = bit_idx + 3'd1;
            end
          STOP_BIT:
            if (byte_idx == LAST_BYTE) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = START_BIT;
              tx_n    = 1'b0;
              byte_n  = byte_idx + 2'd1;
            end
          default: ;
        endcase
    end
  end
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed vector bench for uart_word_tx (BAUD_DIV=4/NUM_BYTES=4 and BAUD_DIV=2/NUM_BYTES=1).
module tb_uart_word_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  uart_word_tx_if bus ();
  uart_word_tx_if bus1 ();
  uart_word_tx #(.BAUD_DIV(4), .NUM_BYTES(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  uart_word_tx #(.BAUD_DIV(2), .NUM_BYTES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_bytes;
    logic        hold;
    logic        poke;
  } vec_t;
  vec_t vecs[5];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // expects start/word_in set so acceptance happens at the next rising edge; returns in the done cycle
  task automatic run_frame(input logic [31:0] w, input logic [31:0] exp_bytes, input logic hold, input logic poke);
    logic [159:0] s;
    logic [7:0] b;
    logic busy_bad, done_bad, unstable;
    busy_bad = 1'b0;
    done_bad = 1'b0;
    unstable = 1'b0;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start = 1'b0;
      bus.word_in = ~w;
    end
    for (int i = 0; i < 160; i++) begin
      s[i] = bus.tx;
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (bus.done !== 1'b0) done_bad = 1'b1;
      if (poke && i == 50) begin
        bus.start = 1'b1;
        bus.word_in = 32'hFFFF_FFFF;
      end
      if (poke && i == 51) bus.start = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 10; k++)
        for (int q = 1; q < 4; q++)
          if (s[40*j+4*k+q] !== s[40*j+4*k]) unstable = 1'b1;
      b = '0;
      for (int k = 0; k < 8; k++) b[k] = s[40*j+4+4*k+2];
      check($sformatf("w%08h byte%0d start bit", w, j), 32'(s[40*j]), 32'd0);
      check($sformatf("w%08h byte%0d data", w, j), 32'(b), 32'(exp_bytes[31-8*j -: 8]));
      check($sformatf("w%08h byte%0d stop bit", w, j), 32'(s[40*j+36]), 32'd1);
    end
    check($sformatf("w%08h bits stable", w), 32'(unstable), 32'd0);
    check($sformatf("w%08h busy in frame", w), 32'(busy_bad), 32'd0);
    check($sformatf("w%08h no early done", w), 32'(done_bad), 32'd0);
    check($sformatf("w%08h done after 160", w), 32'(bus.done), 32'd1);
    check($sformatf("w%08h busy low at done", w), 32'(bus.busy), 32'd0);
    check($sformatf("w%08h tx high at done", w), 32'(bus.tx), 32'd1);
  endtask
  initial begin
    logic idle_bad;
    logic busy1_bad;
    logic [19:0] s1;
    bus.start = 1'b0;
    bus.word_in = '0;
    bus1.start = 1'b0;
    bus1.word_in = '0;
    vecs[0] = '{32'h1234_5678, 32'h7856_3412, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_00FF, 32'hFF00_0000, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0001, 32'h0100_0080, 1'b0, 1'b0};
    vecs[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0};
    vecs[4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset tx nb1", 32'(bus1.tx), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) idle_bad = 1'b1;
      if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) idle_bad = 1'b1;
    end
    check("idle 1000 cycles", 32'(idle_bad), 32'd0);
    foreach (vecs[v]) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.word_in = vecs[v].word;
      run_frame(vecs[v].word, vecs[v].exp_bytes, vecs[v].hold, vecs[v].poke);
    end
    @(posedge clk);
    #1;
    check("done one cycle", 32'(bus.done), 32'd0);
    check("stays idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.word_in = 32'h0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    check("tx low before abort", 32'(bus.tx), 32'd0);
    reset = 1'b0;
    #1;
    check("abort tx async", 32'(bus.tx), 32'd1);
    check("abort busy async", 32'(bus.busy), 32'd0);
    check("abort done async", 32'(bus.done), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.word_in = 32'h0000_00FF;
    run_frame(32'h0000_00FF, 32'hFF00_0000, 1'b0, 1'b0);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.word_in = 32'hDEAD_BE01;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus1.word_in = '0;
    busy1_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s1[i] = bus1.tx;
      if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) busy1_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    check("nb1 frame bits", 32'(s1), 32'h000C_000C);
    check("nb1 busy in frame", 32'(busy1_bad), 32'd0);
    check("nb1 done after 20", 32'(bus1.done), 32'd1);
    check("nb1 busy low at done", 32'(bus1.busy), 32'd0);
    @(posedge clk);
    #1;
    check("nb1 done one cycle", 32'(bus1.done), 32'd0);
    check("nb1 tx idle", 32'(bus1.tx), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
